// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller feeding the instruction fetch buffer.
// Owns the fetch PC, issues tagged 64-bit line reads, holds one returned
// line and emits one 32-bit instruction per cycle with its branch
// prediction attached. A flush redirects the PC and drops any response
// still outstanding for the old path.
//
// Optional build macro: IF_PERF_CNT_EN adds two 32-bit saturating stall
// counters (memory stall, fetch-buffer-full stall). Without it both
// counter ports are tied to zero.
module if_fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [1:0]       proc2Imem_command_o,
  output logic [63:0]      proc2Imem_addr_o,
  input  logic [TAG_W-1:0] Imem2proc_response_i,
  input  logic [63:0]      Imem2proc_data_i,
  input  logic [TAG_W-1:0] Imem2proc_tag_i,
  output logic [63:0]      if2bp_PC_o,
  input  logic             bp2if_pred_bit_i,
  input  logic [63:0]      bp2if_target_PC_i,
  input  logic             flush_en_i,
  input  logic [63:0]      flush_target_PC_i,
  input  logic             ifb_full_i,
  output logic             if_valid_o,
  output logic [31:0]      if_insn_o,
  output logic [63:0]      if_PC_o,
  output logic [63:0]      if_target_PC_o,
  output logic             if_pred_bit_o,
  output logic [31:0]      perf_mem_stall_o,
  output logic [31:0]      perf_full_stall_o
);

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_LOAD = 2'b01;

  // REQ: free to issue; WAIT: line outstanding; DISCARD: outstanding line is stale
  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t           state;
  logic [63:0]      pc;
  logic [63:0]      line_r;
  logic [60:0]      line_addr;
  logic             line_valid;
  logic [TAG_W-1:0] pend_tag;

  logic             line_hit;
  logic             issue;
  logic             accepted;
  logic             tag_match;
  logic             emit;
  logic [63:0]      next_pc;
  logic [31:0]      insn_sel;

  // Hit/issue/emit decode shared by the state update and the outputs
  always_comb begin
    line_hit  = line_valid && (line_addr == pc[63:3]);
    issue     = (state == S_REQ) && !line_hit && !flush_en_i;
    accepted  = issue && (Imem2proc_response_i != '0);
    tag_match = (Imem2proc_tag_i != '0) && (Imem2proc_tag_i == pend_tag);
    emit      = line_hit && !ifb_full_i && !flush_en_i;
    next_pc   = bp2if_pred_bit_i ? bp2if_target_PC_i : (pc + 64'd4);
    insn_sel  = pc[2] ? line_r[63:32] : line_r[31:0];
  end

  // Control state: PC, fetch FSM, line-valid flag and outstanding tag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      state      <= S_REQ;
      line_valid <= 1'b0;
      pend_tag   <= '0;
    end else if (flush_en_i) begin
      pc         <= flush_target_PC_i;
      line_valid <= 1'b0;
      case (state)
        // A response that lands with the flush clears the only tracked tag,
        // so there is nothing left to discard; otherwise wait it out.
        S_WAIT, S_DISCARD: state <= tag_match ? S_REQ : S_DISCARD;
        default:           state <= S_REQ;
      endcase
    end else begin
      if (emit) begin
        pc <= next_pc;
      end
      case (state)
        S_REQ: begin
          if (accepted) begin
            pend_tag <= Imem2proc_response_i;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tag_match) begin
            line_valid <= 1'b1;
            state      <= S_REQ;
          end
        end
        S_DISCARD: begin
          if (tag_match) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  // Line data capture; guarded by line_valid so it needs no reset
  always_ff @(posedge clk) begin
    if (rst_n && !flush_en_i && (state == S_WAIT) && tag_match) begin
      line_r    <= Imem2proc_data_i;
      line_addr <= pc[63:3];
    end
  end

  // Everything except the predictor lookup PC is forced to zero in reset
  always_comb begin
    proc2Imem_command_o = (rst_n && issue) ? CMD_LOAD : CMD_NONE;
    proc2Imem_addr_o    = rst_n ? {pc[63:3], 3'b000} : 64'd0;
    if2bp_PC_o          = pc;
    if_valid_o          = rst_n && emit;
    if_insn_o           = rst_n ? insn_sel : 32'd0;
    if_PC_o             = rst_n ? pc : 64'd0;
    if_target_PC_o      = rst_n ? next_pc : 64'd0;
    if_pred_bit_o       = rst_n && bp2if_pred_bit_i;
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] mem_stall_cnt;
  logic [31:0] full_stall_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

  // Stall counters: memory not serving us, or line present but buffer full
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_stall_cnt  <= 32'd0;
      full_stall_cnt <= 32'd0;
    end else begin
      if ((state != S_REQ) || (issue && (Imem2proc_response_i == '0))) begin
        mem_stall_cnt <= sat_inc(mem_stall_cnt);
      end
      if (line_hit && ifb_full_i) begin
        full_stall_cnt <= sat_inc(full_stall_cnt);
      end
    end
  end

  assign perf_mem_stall_o  = rst_n ? mem_stall_cnt : 32'd0;
  assign perf_full_stall_o = rst_n ? full_stall_cnt : 32'd0;
`else
  assign perf_mem_stall_o  = 32'd0;
  assign perf_full_stall_o = 32'd0;
`endif

endmodule
